// File: rtl/mem_io_bridge.sv
// Bridge from a simple req_rd/req_wr bus to an async SRAM, with an optional hex/switch IO port.
// Defining HEX_IO_EN maps the all-ones address to the hex display (write) and switches (read).
module mem_io_bridge #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int WAIT_CYC = 2,
    parameter int NUM_HEX  = 4,
    parameter int SW_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic                  busy,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    input  logic [SW_W-1:0]       sw,
    output logic [4*NUM_HEX-1:0]  hex_out
);

    localparam int CNT_W = $clog2(WAIT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
    logic                req_any;
    logic                io_hit;

    assign req_any = req_rd | req_wr;

`ifdef HEX_IO_EN
    assign io_hit = (addr == {ADDR_W{1'b1}});
`else
    assign io_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        rdata_d      = rdata_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    // Write wins when both request lines are high.
                    wr_d         = req_wr;
                    sram_addr_d  = addr;
                    sram_wdata_d = wdata;
                    if (io_hit) begin
                        state_d = DONE;
                        if (!req_wr) rdata_d = DATA_W'(sw);
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_W'(WAIT_CYC - 1);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!wr_q) rdata_d = sram_rdata;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            rdata_q      <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            rdata_q      <= rdata_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

`ifdef HEX_IO_EN
    logic [4*NUM_HEX-1:0] hex_q, hex_d;

    always_comb begin
        hex_d = hex_q;
        if (state_q == IDLE && req_wr && io_hit) hex_d = wdata[4*NUM_HEX-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hex_q <= '0;
        else        hex_q <= hex_d;
    end

    assign hex_out = hex_q;
`else
    assign hex_out = '0;
`endif

    // Strobes decode straight from state so an async reset releases them immediately.
    assign sram_oe_n  = !(state_q == ACCESS && !wr_q);
    assign sram_we_n  = !(state_q == ACCESS &&  wr_q);
    assign ready      = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign rdata      = rdata_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge at default parameters; follows HEX_IO_EN for the IO checks.
module tb_mem_io_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_rd, req_wr;
    logic [15:0] addr, wdata, rdata, sram_addr, sram_wdata, sram_rdata, hex_out;
    logic        ready, busy, sram_oe_n, sram_we_n;
    logic [9:0]  sw;

    int n_chk  = 0;
    int n_fail = 0;

    mem_io_bridge #(.DATA_W(16), .ADDR_W(16), .WAIT_CYC(2), .NUM_HEX(4), .SW_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sw(sw), .hex_out(hex_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; req_rd = 0; req_wr = 0; addr = 0; wdata = 0; sram_rdata = 0; sw = 0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_rdata", rdata, 0);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_saddr", sram_addr, 0);
        chk("rst_swdata", sram_wdata, 0);
        chk("rst_hex", hex_out, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // memory read
        req_rd = 1; addr = 16'h0010; sram_rdata = 16'hBEEF;
        tick(); req_rd = 0;
        chk("rd_c1_busy", busy, 1);
        chk("rd_c1_oe", sram_oe_n, 0);
        chk("rd_c1_we", sram_we_n, 1);
        chk("rd_c1_rdy", ready, 0);
        chk("rd_c1_addr", sram_addr, 16'h0010);
        tick();
        chk("rd_c2_oe", sram_oe_n, 0);
        chk("rd_c2_rdy", ready, 0);
        tick();
        chk("rd_c3_rdy", ready, 1);
        chk("rd_c3_oe", sram_oe_n, 1);
        chk("rd_c3_rdata", rdata, 16'hBEEF);
        tick();
        chk("rd_c4_rdy", ready, 0);
        chk("rd_c4_busy", busy, 0);

        // memory write
        req_wr = 1; addr = 16'h0020; wdata = 16'h1234; sram_rdata = 16'h0000;
        tick(); req_wr = 0;
        chk("wr_c1_we", sram_we_n, 0);
        chk("wr_c1_oe", sram_oe_n, 1);
        chk("wr_c1_addr", sram_addr, 16'h0020);
        chk("wr_c1_wdata", sram_wdata, 16'h1234);
        tick();
        chk("wr_c2_we", sram_we_n, 0);
        chk("wr_c2_rdy", ready, 0);
        tick();
        chk("wr_c3_rdy", ready, 1);
        chk("wr_c3_we", sram_we_n, 1);
        chk("wr_rdata_hold", rdata, 16'hBEEF);
        tick();
        chk("wr_c4_rdy", ready, 0);

`ifdef HEX_IO_EN
        // IO write then IO read
        req_wr = 1; addr = 16'hFFFF; wdata = 16'hA5C3;
        tick(); req_wr = 0;
        chk("iow_rdy", ready, 1);
        chk("iow_hex", hex_out, 16'hA5C3);
        chk("iow_oe", sram_oe_n, 1);
        chk("iow_we", sram_we_n, 1);
        tick();
        chk("iow_idle", busy, 0);
        req_rd = 1; addr = 16'hFFFF; sw = 10'h3FF;
        tick(); req_rd = 0;
        chk("ior_rdy", ready, 1);
        chk("ior_rdata", rdata, 16'h03FF);
        chk("ior_oe", sram_oe_n, 1);
        chk("ior_hex_hold", hex_out, 16'hA5C3);
        tick();
        chk("ior_idle", ready, 0);
`else
        // all-ones address is plain memory without the IO feature
        req_wr = 1; addr = 16'hFFFF; wdata = 16'h5555; sw = 10'h3FF;
        tick(); req_wr = 0;
        chk("off_we", sram_we_n, 0);
        chk("off_rdy_c1", ready, 0);
        chk("off_saddr", sram_addr, 16'hFFFF);
        chk("off_hex_c1", hex_out, 0);
        tick(); tick();
        chk("off_rdy_c3", ready, 1);
        chk("off_hex_c3", hex_out, 0);
        tick();
`endif

        // rd+wr together is a write; new request while busy is ignored
        req_rd = 1; req_wr = 1; addr = 16'h0030; wdata = 16'h7777;
        tick();
        req_wr = 0; addr = 16'h0040;
        chk("cf_we", sram_we_n, 0);
        chk("cf_oe", sram_oe_n, 1);
        chk("cf_addr", sram_addr, 16'h0030);
        tick();
        chk("cf_c2_addr", sram_addr, 16'h0030);
        tick();
        chk("cf_c3_rdy", ready, 1);
        req_rd = 0;
        tick();
        chk("cf_c4_rdy", ready, 0);
        chk("cf_c4_busy", busy, 0);
        chk("cf_c4_addr", sram_addr, 16'h0030);
        tick();
        chk("cf_no_2nd_rdy", ready, 0);
        chk("cf_no_2nd_busy", busy, 0);

        // reset mid-access
        rst_n = 0; #2;
        chk("rst2_rdata", rdata, 0);
        chk("rst2_hex", hex_out, 0);
        tick(); rst_n = 1; tick();
        req_rd = 1; addr = 16'h0050; sram_rdata = 16'hDEAD;
        tick(); req_rd = 0;
        chk("ab_c1_oe", sram_oe_n, 0);
        tick();
        chk("ab_c2_oe", sram_oe_n, 0);
        #2 rst_n = 0; #1;
        chk("ab_oe", sram_oe_n, 1);
        chk("ab_we", sram_we_n, 1);
        chk("ab_busy", busy, 0);
        chk("ab_rdy", ready, 0);
        chk("ab_rdata", rdata, 0);
        tick();
        rst_n = 1;
        tick();
        chk("ab_post_rdata", rdata, 0);
        chk("ab_post_busy", busy, 0);
        chk("ab_post_rdy", ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
